// File: rtl/cmac_mult16_seq_ctrl.sv
// cmac_mult16_seq_ctrl
// Computes one 16x16 signed product by walking a single shared unsigned 8x8
// multiplier through the four byte pairs of the operand magnitudes, then
// re-applies the sign and returns a 32-bit result over valid/ready.
// Zero-magnitude operands can bypass the partial-product walk (ZERO_SKIP).
module cmac_mult16_seq_ctrl #(
  parameter int ZERO_SKIP = 1,
  parameter int CNT_W     = 16
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             mul_en,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PP0  = 3'd1;
  localparam logic [2:0] S_PP1  = 3'd2;
  localparam logic [2:0] S_PP2  = 3'd3;
  localparam logic [2:0] S_PP3  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state;
  logic [15:0] ma;
  logic [15:0] mb;
  logic        sgn;
  logic [31:0] acc;
  logic [31:0] pp_shifted;
  logic [31:0] acc_nxt;
  logic [15:0] abs_a;
  logic [15:0] abs_b;
  logic        sgn_in;
  logic        zero_op;

  // Two's-complement magnitude; 0x8000 maps to itself and is read as unsigned 32768.
  function automatic logic [15:0] mag16(input logic signed [15:0] x);
    logic [15:0] ux;
    ux = x;
    return x[15] ? (~ux + 16'd1) : ux;
  endfunction

  // Re-apply the sign to a magnitude; bit 31 always carries the sign, so a zero
  // product with opposite-sign operands comes out as 0x80000000.
  function automatic logic [31:0] sign_pack(input logic s, input logic [31:0] m);
    logic [31:0] t;
    t = s ? (~m + 32'd1) : m;
    return {s, t[30:0]};
  endfunction

  assign abs_a   = mag16(in_a);
  assign abs_b   = mag16(in_b);
  assign sgn_in  = in_a[15] ^ in_b[15];
  assign zero_op = (ZERO_SKIP != 0) && ((abs_a == 16'd0) || (abs_b == 16'd0));

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // Byte-pair selection for the shared multiplier and alignment of its product.
  always_comb begin
    mul_en     = 1'b0;
    mul_a      = 8'd0;
    mul_b      = 8'd0;
    pp_shifted = 32'd0;
    case (state)
      S_PP0: begin
        mul_en     = 1'b1;
        mul_a      = ma[7:0];
        mul_b      = mb[7:0];
        pp_shifted = {16'd0, mul_p};
      end
      S_PP1: begin
        mul_en     = 1'b1;
        mul_a      = ma[15:8];
        mul_b      = mb[7:0];
        pp_shifted = {8'd0, mul_p, 8'd0};
      end
      S_PP2: begin
        mul_en     = 1'b1;
        mul_a      = ma[7:0];
        mul_b      = mb[15:8];
        pp_shifted = {8'd0, mul_p, 8'd0};
      end
      S_PP3: begin
        mul_en     = 1'b1;
        mul_a      = ma[15:8];
        mul_b      = mb[15:8];
        pp_shifted = {mul_p, 16'd0};
      end
      default: ;
    endcase
  end

  assign acc_nxt = acc + pp_shifted;

  // Sequencer: operand capture, partial-product accumulation, result hold.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state    <= S_IDLE;
      ma       <= 16'd0;
      mb       <= 16'd0;
      sgn      <= 1'b0;
      acc      <= 32'd0;
      out_data <= 32'd0;
      op_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ma  <= abs_a;
            mb  <= abs_b;
            sgn <= sgn_in;
            acc <= 32'd0;
            if (zero_op) begin
              out_data <= sign_pack(sgn_in, 32'd0);
              state    <= S_DONE;
            end else begin
              state <= S_PP0;
            end
          end
        end
        S_PP0: begin
          acc   <= acc_nxt;
          state <= S_PP1;
        end
        S_PP1: begin
          acc   <= acc_nxt;
          state <= S_PP2;
        end
        S_PP2: begin
          acc   <= acc_nxt;
          state <= S_PP3;
        end
        S_PP3: begin
          acc      <= acc_nxt;
          out_data <= sign_pack(sgn, acc_nxt);
          state    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            op_cnt <= op_cnt + CNT_W'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_mult16_seq_ctrl.sv
// Directed bench for cmac_mult16_seq_ctrl. Three instances share the operand
// stream: default parameters, ZERO_SKIP=0, and CNT_W=4 for counter wrap.
module tb_cmac_mult16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;

  logic        in_ready_m, mul_en_m, out_valid_m, busy_m;
  logic [7:0]  mul_a_m, mul_b_m;
  logic [15:0] mul_p_m, op_cnt_m;
  logic [31:0] out_data_m;

  logic        in_ready_n, mul_en_n, out_valid_n, busy_n;
  logic [7:0]  mul_a_n, mul_b_n;
  logic [15:0] mul_p_n, op_cnt_n;
  logic [31:0] out_data_n;

  logic        in_ready_w, mul_en_w, out_valid_w, busy_w;
  logic [7:0]  mul_a_w, mul_b_w;
  logic [15:0] mul_p_w;
  logic [3:0]  op_cnt_w;
  logic [31:0] out_data_w;

  always #5 clk = ~clk;

  assign mul_p_m = {8'd0, mul_a_m} * {8'd0, mul_b_m};
  assign mul_p_n = {8'd0, mul_a_n} * {8'd0, mul_b_n};
  assign mul_p_w = {8'd0, mul_a_w} * {8'd0, mul_b_w};

  cmac_mult16_seq_ctrl #(.ZERO_SKIP(1), .CNT_W(16)) dut_m (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_a(in_a), .in_b(in_b),
    .mul_en(mul_en_m), .mul_a(mul_a_m), .mul_b(mul_b_m), .mul_p(mul_p_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .busy(busy_m), .op_cnt(op_cnt_m));

  cmac_mult16_seq_ctrl #(.ZERO_SKIP(0), .CNT_W(16)) dut_n (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_a(in_a), .in_b(in_b),
    .mul_en(mul_en_n), .mul_a(mul_a_n), .mul_b(mul_b_n), .mul_p(mul_p_n),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .busy(busy_n), .op_cnt(op_cnt_n));

  cmac_mult16_seq_ctrl #(.ZERO_SKIP(1), .CNT_W(4)) dut_w (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b),
    .mul_en(mul_en_w), .mul_a(mul_a_w), .mul_b(mul_b_w), .mul_p(mul_p_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .busy(busy_w), .op_cnt(op_cnt_w));

  int errors = 0;
  int checks = 0;

  int          lat_m, lat_n, lat_w, men_m, men_n, nseq;
  logic [31:0] dat_m, dat_n, dat_w;
  logic [15:0] seq [4];
  logic [15:0] exp_cnt;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full signed product, with bit 31 forced to the XOR of operand signs.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb, p;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    p  = sa * sb;
    return {a[15] ^ b[15], p[30:0]};
  endfunction

  // Issue one operand pair with out_ready high and watch all three instances
  // until each has produced its result and returned to idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    lat_m = 0; lat_n = 0; lat_w = 0; men_m = 0; men_n = 0; nseq = 0;
    dat_m = '0; dat_n = '0; dat_w = '0;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (out_valid_m && lat_m == 0) begin lat_m = k; dat_m = out_data_m; end
      if (out_valid_n && lat_n == 0) begin lat_n = k; dat_n = out_data_n; end
      if (out_valid_w && lat_w == 0) begin lat_w = k; dat_w = out_data_w; end
      if (mul_en_m) begin
        if (nseq < 4) seq[nseq] = {mul_a_m, mul_b_m};
        nseq++;
        men_m++;
      end
      if (mul_en_n) men_n++;
      if (!busy_m && !busy_n && !busy_w && lat_m != 0 && lat_n != 0 && lat_w != 0) break;
      @(posedge clk); #1;
    end
    chk("op_completes", {31'd0, (lat_m != 0 && lat_n != 0 && lat_w != 0 && !busy_m && !busy_n)}, 32'd1);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);
    chk("rst_op_cnt", {16'd0, op_cnt_m}, 32'd0);
    chk("rst_mul", {23'd0, mul_en_m, mul_a_m, mul_b_m}, 32'd0);
    chk("rst_out_data", out_data_m, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready_m}, 32'd1);

    // Abort an operation with reset while in PP2.
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pp2_mul_ab", {16'd0, mul_a_m, mul_b_m}, 32'h0000_3456);
    rstn = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_m}, 32'd0);
    chk("abort_mul_en", {31'd0, mul_en_m}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("abort_op_cnt", {16'd0, op_cnt_m}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready_m}, 32'd1);
    chk("abort_out_valid2", {31'd0, out_valid_m}, 32'd0);

    run_op(16'h0003, 16'h0004);
    exp_cnt = exp_cnt + 16'd1;
    chk("3x4_data", dat_m, 32'h0000_000C);
    chk("3x4_lat", lat_m, 32'd5);
    chk("3x4_cnt", {16'd0, op_cnt_m}, {16'd0, exp_cnt});

    run_op(16'h1234, 16'h5678);
    exp_cnt = exp_cnt + 16'd1;
    chk("1234_data", dat_m, 32'h0626_0060);
    chk("1234_lat", lat_m, 32'd5);
    chk("1234_mulcnt", men_m, 32'd4);
    chk("1234_seq0", {16'd0, seq[0]}, 32'h0000_3478);
    chk("1234_seq1", {16'd0, seq[1]}, 32'h0000_1278);
    chk("1234_seq2", {16'd0, seq[2]}, 32'h0000_3456);
    chk("1234_seq3", {16'd0, seq[3]}, 32'h0000_1256);
    chk("1234_cnt", {16'd0, op_cnt_m}, {16'd0, exp_cnt});

    run_op(16'hFFFE, 16'h0003);
    exp_cnt = exp_cnt + 16'd1;
    chk("neg2x3", dat_m, 32'hFFFF_FFFA);
    run_op(16'h8000, 16'h8000);
    exp_cnt = exp_cnt + 16'd1;
    chk("min_x_min", dat_m, 32'h4000_0000);
    run_op(16'h7FFF, 16'h8001);
    exp_cnt = exp_cnt + 16'd1;
    chk("max_x_negmax", dat_m, 32'hC000_FFFF);
    run_op(16'hFFFF, 16'hFFFF);
    exp_cnt = exp_cnt + 16'd1;
    chk("neg1_x_neg1", dat_m, 32'h0000_0001);

    // Zero operand: skipped on dut_m, full walk on dut_n.
    run_op(16'h0000, 16'hFFFF);
    exp_cnt = exp_cnt + 16'd1;
    chk("zskip_data", dat_m, 32'h8000_0000);
    chk("zskip_lat", lat_m, 32'd1);
    chk("zskip_mulcnt", men_m, 32'd0);
    chk("noskip_data", dat_n, 32'h8000_0000);
    chk("noskip_lat", lat_n, 32'd5);
    chk("noskip_mulcnt", men_n, 32'd4);
    chk("zero_cnt", {16'd0, op_cnt_m}, {16'd0, exp_cnt});
    chk("zero_cnt_n", {16'd0, op_cnt_n}, {16'd0, exp_cnt});

    // Backpressure: result held in DONE for 10 cycles with competing in_valid.
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", {31'd0, out_valid_m}, 32'd1);
    chk("bp_data", out_data_m, 32'h0000_369C);
    held = out_data_m;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a = 16'h0005; in_b = 16'h0005; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_stable", out_data_m, held);
      chk("bp_in_ready", {31'd0, in_ready_m}, 32'd0);
    end
    chk("bp_cnt_hold", {16'd0, op_cnt_m}, {16'd0, exp_cnt});
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_release_valid", {31'd0, out_valid_m}, 32'd0);
    chk("bp_release_cnt", {16'd0, op_cnt_m}, {16'd0, exp_cnt});
    @(posedge clk); #1;
    chk("bp_no_restart", {31'd0, busy_m}, 32'd0);
    chk("bp_single_inc", {16'd0, op_cnt_m}, {16'd0, exp_cnt});

    // Fresh counters, then 100 random pairs back to back.
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb);
      chk("rand_m", dat_m, model(ra, rb));
      chk("rand_n", dat_n, model(ra, rb));
    end
    chk("rand_cnt", {16'd0, op_cnt_m}, 32'd100);
    chk("rand_cnt_n", {16'd0, op_cnt_n}, 32'd100);
    chk("rand_cnt_wrap", {28'd0, op_cnt_w}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
